// File: rtl/decoder_pipe.sv
// ----------------------------------------------------------------------------
// decoder_pipe
//
// Purpose:
//   One-stage pipelined select decoder with a valid/ready handshake on both
//   sides. Each accepted select code is decoded according to 'mode' and
//   appears on 'out' exactly one cycle later. The four decode styles are
//   one-hot, thermometer, accumulate (OR into a sticky register) and
//   active-low one-hot. A free-running counter tracks accepted transactions.
//
// Parameters:
//   SEL_W  - select code width (1..6)
//   CNT_W  - accepted-transaction counter width
//   OUT_W  - decoded vector width, fixed at 2**SEL_W
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in         in   [SEL_W] select code
//   en         in   decode enable, qualified with 'in'
//   mode       in   [2] 00 one-hot, 01 thermometer, 10 accumulate, 11 ~one-hot
//   in_valid   in   upstream has a valid in/en/mode
//   in_ready   out  block can accept this cycle
//   clr        in   synchronous accumulator clear
//   out        out  [OUT_W] registered decoded vector
//   out_valid  out  'out' holds an unconsumed result
//   out_ready  in   downstream takes the result this cycle
//   count      out  [CNT_W] number of accepted transactions (wraps)
// ----------------------------------------------------------------------------
module decoder_pipe #(
    parameter  int SEL_W = 3,
    parameter  int CNT_W = 8,
    localparam int OUT_W = 2 ** SEL_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [SEL_W-1:0] in,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             clr,
    output logic [OUT_W-1:0] out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] count
);

    localparam logic [1:0] MODE_ONEHOT = 2'b00;
    localparam logic [1:0] MODE_THERM  = 2'b01;
    localparam logic [1:0] MODE_ACCUM  = 2'b10;
    localparam logic [1:0] MODE_NHOT   = 2'b11;

    logic [OUT_W-1:0] r_out;
    logic             r_outValid;
    logic [OUT_W-1:0] r_acc;
    logic [CNT_W-1:0] r_count;

    logic             w_accept;
    logic [OUT_W-1:0] w_onehot;
    logic [OUT_W-1:0] w_therm;
    logic [OUT_W-1:0] w_accBase;
    logic [OUT_W-1:0] w_result;

    // Single-entry pipe: a new item may enter whenever the output slot is
    // empty or is being drained in this same cycle.
    assign in_ready = !r_outValid || out_ready;
    assign w_accept = in_valid && in_ready;

    // A clear arriving with an accumulate accept takes effect first, so the
    // accumulate operand starts from zero in that case.
    assign w_accBase = clr ? '0 : r_acc;

    // Basic decodes of the select code.
    always_comb begin
        w_onehot = OUT_W'(1) << in;
        w_therm  = '0;
        for (int i = 0; i < OUT_W; i++) begin
            w_therm[i] = (i <= int'(in));
        end
    end

    // Decoded value for the current input. With en low the one-hot and
    // thermometer styles go quiet (zeros), active-low goes all ones and the
    // accumulator simply reports its (possibly cleared) content.
    always_comb begin
        w_result = '0;
        case (mode)
            MODE_ONEHOT: w_result = en ? w_onehot : '0;
            MODE_THERM:  w_result = en ? w_therm : '0;
            MODE_ACCUM:  w_result = en ? (w_accBase | w_onehot) : w_accBase;
            MODE_NHOT:   w_result = en ? ~w_onehot : '1;
        endcase
    end

    // Output stage: load on accept, release the slot when downstream takes
    // it and nothing new arrives. Without accept the data is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out      <= '0;
            r_outValid <= 1'b0;
        end else if (w_accept) begin
            r_out      <= w_result;
            r_outValid <= 1'b1;
        end else if (out_ready) begin
            r_outValid <= 1'b0;
        end
    end

    // Accumulator only follows accumulate-mode accepts and clr. An accumulate
    // accept already folds clr into w_result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (w_accept && (mode == MODE_ACCUM)) begin
            r_acc <= w_result;
        end else if (clr) begin
            r_acc <= '0;
        end
    end

    // Transaction counter, wraps naturally at its width.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (w_accept) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign out       = r_out;
    assign out_valid = r_outValid;
    assign count     = r_count;

endmodule

// File: tb/tb_decoder_pipe.sv
// ----------------------------------------------------------------------------
// tb_decoder_pipe
//
// Self-checking bench for decoder_pipe. A main instance (SEL_W=3, CNT_W=8)
// is driven from a table of directed vectors, followed by hand-written
// sequences for clear, back-pressure, accumulator isolation and mid-stream
// reset. A second instance with CNT_W=2 shares all inputs so its wrapping
// counter can be compared alongside.
// ----------------------------------------------------------------------------
module tb_decoder_pipe;

    // Clock and shared stimulus
    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] selIn;
    logic       en;
    logic [1:0] mode;
    logic       inValid;
    logic       clr;
    logic       outReady;

    // Main instance outputs
    logic       inReady;
    logic [7:0] outVec;
    logic       outValid;
    logic [7:0] count;

    // Narrow-counter instance outputs
    logic       inReady2;
    logic [7:0] outVec2;
    logic       outValid2;
    logic [1:0] count2;

    int compared   = 0;
    int mismatched = 0;

    // Directed vector record: inputs plus expected decoded output
    typedef struct {
        logic [1:0] mode;
        logic       en;
        logic [2:0] sel;
        logic [7:0] expOut;
    } vec_t;

    vec_t vecs[17];

    // 100 MHz-style free-running clock
    always #5 clk = ~clk;

    decoder_pipe #(.SEL_W(3), .CNT_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in       (selIn),
        .en       (en),
        .mode     (mode),
        .in_valid (inValid),
        .in_ready (inReady),
        .clr      (clr),
        .out      (outVec),
        .out_valid(outValid),
        .out_ready(outReady),
        .count    (count)
    );

    decoder_pipe #(.SEL_W(3), .CNT_W(2)) dut2 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in       (selIn),
        .en       (en),
        .mode     (mode),
        .in_valid (inValid),
        .in_ready (inReady2),
        .clr      (clr),
        .out      (outVec2),
        .out_valid(outValid2),
        .out_ready(outReady),
        .count    (count2)
    );

    // Compare one observed value against its expectation and tally it
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Drive one set of inputs (blocking, away from the clock edge)
    task automatic applyStimulus(input logic [1:0] m, input logic e,
                                 input logic [2:0] s, input logic v,
                                 input logic c, input logic r);
        mode     = m;
        en       = e;
        selIn    = s;
        inValid  = v;
        clr      = c;
        outReady = r;
    endtask

    // Advance one clock and settle just after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Expected decodes computed by hand for SEL_W=3
        vecs[0]  = '{2'b00, 1'b1, 3'd0, 8'h01};
        vecs[1]  = '{2'b00, 1'b1, 3'd1, 8'h02};
        vecs[2]  = '{2'b00, 1'b1, 3'd2, 8'h04};
        vecs[3]  = '{2'b00, 1'b1, 3'd3, 8'h08};
        vecs[4]  = '{2'b00, 1'b1, 3'd4, 8'h10};
        vecs[5]  = '{2'b00, 1'b1, 3'd5, 8'h20};
        vecs[6]  = '{2'b00, 1'b1, 3'd6, 8'h40};
        vecs[7]  = '{2'b00, 1'b1, 3'd7, 8'h80};
        vecs[8]  = '{2'b01, 1'b1, 3'd5, 8'h3F};
        vecs[9]  = '{2'b01, 1'b1, 3'd7, 8'hFF};
        vecs[10] = '{2'b01, 1'b1, 3'd0, 8'h01};
        vecs[11] = '{2'b11, 1'b1, 3'd2, 8'hFB};
        vecs[12] = '{2'b11, 1'b0, 3'd2, 8'hFF};
        vecs[13] = '{2'b00, 1'b0, 3'd4, 8'h00};
        vecs[14] = '{2'b10, 1'b1, 3'd1, 8'h02};
        vecs[15] = '{2'b10, 1'b1, 3'd4, 8'h12};
        vecs[16] = '{2'b10, 1'b1, 3'd6, 8'h52};

        // Reset with idle inputs; in_ready must read 1 while held
        rst_n = 1'b0;
        applyStimulus(2'b00, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset out", 32'(outVec), 32'h00);
        checkOutput("reset out_valid", 32'(outValid), 32'h0);
        checkOutput("reset count", 32'(count), 32'h0);
        checkOutput("reset in_ready", 32'(inReady), 32'h1);
        rst_n = 1'b1;

        // Table vectors back-to-back with downstream always ready
        for (int i = 0; i < 17; i++) begin
            applyStimulus(vecs[i].mode, vecs[i].en, vecs[i].sel, 1'b1, 1'b0, 1'b1);
            #1;
            checkOutput($sformatf("vec%0d in_ready", i), 32'(inReady), 32'h1);
            tick();
            checkOutput($sformatf("vec%0d out", i), 32'(outVec), 32'(vecs[i].expOut));
            checkOutput($sformatf("vec%0d out_valid", i), 32'(outValid), 32'h1);
            if (i == 7) begin
                checkOutput("count after onehot sweep", 32'(count), 32'd8);
            end
        end
        checkOutput("count after table", 32'(count), 32'd17);

        // clr alone while downstream stalls: output untouched, acc cleared
        applyStimulus(2'b10, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0);
        tick();
        checkOutput("clr alone out held", 32'(outVec), 32'h52);
        checkOutput("clr alone out_valid", 32'(outValid), 32'h1);
        checkOutput("clr alone count", 32'(count), 32'd17);
        applyStimulus(2'b10, 1'b1, 3'd0, 1'b1, 1'b0, 1'b1);
        tick();
        checkOutput("accum after clr", 32'(outVec), 32'h01);

        // clr together with an accumulate accept: clear applies first
        applyStimulus(2'b10, 1'b1, 3'd3, 1'b1, 1'b1, 1'b1);
        tick();
        checkOutput("clr with accept", 32'(outVec), 32'h08);
        checkOutput("count after clr accept", 32'(count), 32'd19);

        // Back-pressure: slot full and not drained, so nothing enters
        applyStimulus(2'b00, 1'b1, 3'd5, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            #1;
            checkOutput($sformatf("stall%0d in_ready", k), 32'(inReady), 32'h0);
            tick();
            checkOutput($sformatf("stall%0d out held", k), 32'(outVec), 32'h08);
            checkOutput($sformatf("stall%0d count", k), 32'(count), 32'd19);
        end
        outReady = 1'b1;
        #1;
        checkOutput("release in_ready", 32'(inReady), 32'h1);
        tick();
        checkOutput("pass-through 1", 32'(outVec), 32'h20);
        applyStimulus(2'b00, 1'b1, 3'd6, 1'b1, 1'b0, 1'b1);
        tick();
        checkOutput("pass-through 2", 32'(outVec), 32'h40);
        checkOutput("count after pass-through", 32'(count), 32'd21);

        // Drain with no new input: out_valid drops
        applyStimulus(2'b00, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1);
        tick();
        checkOutput("drain out_valid", 32'(outValid), 32'h0);

        // Accumulator isolation: en=0 reports acc, other modes leave it alone
        applyStimulus(2'b10, 1'b0, 3'd5, 1'b1, 1'b0, 1'b1);
        tick();
        checkOutput("accum en=0", 32'(outVec), 32'h08);
        applyStimulus(2'b00, 1'b1, 3'd7, 1'b1, 1'b0, 1'b1);
        tick();
        checkOutput("onehot between accum", 32'(outVec), 32'h80);
        applyStimulus(2'b10, 1'b1, 3'd2, 1'b1, 1'b0, 1'b1);
        tick();
        checkOutput("accum resumes", 32'(outVec), 32'h0C);
        checkOutput("count before reset", 32'(count), 32'd24);

        // Fresh reset, then build out_valid=1, count=5, acc=0x12 while
        // watching the 2-bit counter wrap
        rst_n = 1'b0;
        applyStimulus(2'b00, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            logic [1:0] expCnt2;
            expCnt2 = 2'(k + 1);
            if (k == 0)      applyStimulus(2'b10, 1'b1, 3'd1, 1'b1, 1'b0, 1'b1);
            else if (k == 1) applyStimulus(2'b10, 1'b1, 3'd4, 1'b1, 1'b0, 1'b1);
            else             applyStimulus(2'b00, 1'b1, 3'd0, 1'b1, 1'b0, 1'b1);
            tick();
            checkOutput($sformatf("narrow count step%0d", k), 32'(count2), 32'(expCnt2));
        end
        checkOutput("pre-reset count", 32'(count), 32'd5);
        checkOutput("pre-reset out_valid", 32'(outValid), 32'h1);

        // Asynchronous reset between edges clears everything at once
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async out", 32'(outVec), 32'h00);
        checkOutput("async out_valid", 32'(outValid), 32'h0);
        checkOutput("async count", 32'(count), 32'h0);
        checkOutput("async in_ready", 32'(inReady), 32'h1);
        applyStimulus(2'b10, 1'b1, 3'd0, 1'b1, 1'b0, 1'b1);
        #1;
        rst_n = 1'b1;
        tick();
        checkOutput("accum after async reset", 32'(outVec), 32'h01);
        checkOutput("count after async reset", 32'(count), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/decoder_pipe.md
DECODER_PIPE -- requirements
Module: decoder_pipe

Interface
REQ-001 The module SHALL have parameter SEL_W, default 3, meaning select width; legal range 1..6.
REQ-002 The module SHALL have parameter CNT_W, default 8, meaning accepted-transaction counter width.
REQ-003 The module SHALL derive localparam OUT_W = 2**SEL_W as the decoded output width.
REQ-004 The module SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 The module SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 The module SHALL have port in, input, SEL_W, the select code.
REQ-007 The module SHALL have port en, input, 1, the decode enable, sampled with in.
REQ-008 The module SHALL have port mode, input, 2: 00 one-hot, 01 thermometer, 10 accumulate, 11 active-low one-hot.
REQ-009 The module SHALL have port in_valid, input, 1, meaning in/en/mode are valid.
REQ-010 The module SHALL have port in_ready, output, 1, meaning the block accepts this cycle.
REQ-011 The module SHALL have port clr, input, 1, the synchronous accumulator clear.
REQ-012 The module SHALL have port out, output, OUT_W, the registered decoded vector.
REQ-013 The module SHALL have port out_valid, output, 1, meaning out holds an unconsumed result.
REQ-014 The module SHALL have port out_ready, input, 1, the downstream accept.
REQ-015 The module SHALL have port count, output, CNT_W, the number of accepted transactions.

Function
REQ-016 Accept SHALL occur when in_valid && in_ready; in_ready SHALL equal !out_valid || out_ready (combinational, one-stage pipe).
REQ-017 Latency SHALL be exactly 1 cycle: an input accepted at edge N SHALL appear on out with out_valid=1 after edge N.
REQ-018 out_valid SHALL set on accept, clear on out_ready with no accept in the same cycle, and stay 1 on simultaneous out_ready and accept.
REQ-019 While out_valid && !out_ready, out SHALL hold stable.
REQ-020 Mode 00 SHALL produce out[in]=1 and all other bits 0.
REQ-021 Mode 01 SHALL produce out[i]=1 for all i<=in and 0 above (in=0 gives 1; in=OUT_W-1 gives all ones).
REQ-022 Mode 10 SHALL produce out = acc | onehot(in); internal register acc SHALL then take this value.
REQ-023 Mode 11 SHALL produce ~onehot(in).
REQ-024 When en=0 at accept, modes 00/01 SHALL produce all zeros, mode 11 SHALL produce all ones, and mode 10 SHALL produce acc unchanged with acc not updated.
REQ-025 acc SHALL be modified only by mode-10 accepts and clr; other modes SHALL leave acc unchanged.
REQ-026 clr without accept SHALL zero acc next edge; out and out_valid SHALL be unaffected.
REQ-027 On clr with a mode-10 accept in the same cycle, clr SHALL apply first: out = acc = onehot(in), or zero if en=0.
REQ-028 count SHALL increment by 1 on every accept (any mode, any en) and SHALL wrap from 2**CNT_W-1 to 0.
REQ-029 All select values SHALL be legal; no default or error path SHALL exist.

Reset
REQ-030 rst_n low SHALL asynchronously force out=0, out_valid=0, acc=0 and count=0, regardless of clk.
REQ-031 in_ready SHALL read 1 during reset.
REQ-032 Release SHALL be synchronised by the integrator; the first accept SHALL be possible on the first edge after rst_n rises.
REQ-033 Reset mid-transaction SHALL discard any pending out with no output.

Verification
REQ-034 SEL_W=3, mode 00, en=1, out_ready=1, in=0..7 back-to-back -> out=01,02,04,...,80 one cycle after each accept; count=8; in_ready constantly 1.
REQ-035 Mode 01, in=5 -> out=8'h3F; in=7 -> 8'hFF; mode 11, in=2 -> 8'hFB; mode 11, en=0 -> 8'hFF; mode 00, en=0 -> 8'h00.
REQ-036 Mode 10 sequence in=1,4,6 -> out=02,12,52; then clr alone -> next in=0 gives 01; clr with accept in=3 -> 08.
REQ-037 out_ready=0 with an accepted result -> in_ready=0, out held for 5 cycles, no count change; out_ready=1 with new in_valid -> pass-through at one per cycle.
REQ-038 Assert rst_n=0 between edges with out_valid=1, count=5, acc=8'h12 -> all four zero immediately; mode 10 in=0 after release -> out=01.
REQ-039 CNT_W=2, 5 accepts -> count 1,2,3,0,1.
